// File: rtl/breath_pwm_multi.sv
// Multi-channel breathing-LED PWM: one shared counter, per-channel staggered duty ramps.
// Optional gamma mapping of the duty is built when BREATH_PWM_GAMMA_EN is defined.
module breath_pwm_multi #(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 4,
  parameter int STEP_DIV = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                mode,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
  localparam int               DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  // Evenly spread starting duties so the channels breathe out of phase.
  function automatic logic [WIDTH-1:0] init_duty(input int i);
    return WIDTH'((i * (1 << WIDTH)) / CHANNELS);
  endfunction

  logic [WIDTH-1:0]    cnt;
  logic [DIV_W-1:0]    div;
  logic [WIDTH-1:0]    duty     [CHANNELS];
  logic [WIDTH-1:0]    duty_nxt [CHANNELS];
  logic [WIDTH-1:0]    eff      [CHANNELS];
  logic [CHANNELS-1:0] dir;
  logic [CHANNELS-1:0] dir_nxt;
  logic [CHANNELS-1:0] cmp;
  logic                cnt_at_max;
  logic                step;

  assign cnt_at_max = (cnt == MAX);
  assign step       = enable && cnt_at_max && (div == DIV_LAST);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_nxt[i] = duty[i];
      dir_nxt[i]  = dir[i];
      if (step) begin
        if (mode) begin
          duty_nxt[i] = duty[i] + WIDTH'(1);
          dir_nxt[i]  = 1'b0;
        end else if (!dir[i]) begin
          if (duty[i] == MAX) begin
            duty_nxt[i] = MAX - WIDTH'(1);
            dir_nxt[i]  = 1'b1;
          end else begin
            duty_nxt[i] = duty[i] + WIDTH'(1);
          end
        end else begin
          if (duty[i] == '0) begin
            duty_nxt[i] = WIDTH'(1);
            dir_nxt[i]  = 1'b0;
          end else begin
            duty_nxt[i] = duty[i] - WIDTH'(1);
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_eff
`ifdef BREATH_PWM_GAMMA_EN
    logic [2*WIDTH-1:0] prod;
    assign prod   = (2*WIDTH)'(duty[g]) * (2*WIDTH)'(duty[g]);
    assign eff[g] = prod[2*WIDTH-1:WIDTH];
`else
    assign eff[g] = duty[g];
`endif
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cmp[i] = (cnt < eff[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      div         <= '0;
      dir         <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty[i] <= init_duty(i);
      end
    end else begin
      pwm_out     <= enable ? cmp : '0;
      period_tick <= enable && cnt_at_max;
      if (enable) begin
        cnt <= cnt + WIDTH'(1);
        if (cnt_at_max) begin
          div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end
      end
      dir <= dir_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        duty[i] <= duty_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_breath_pwm_multi.sv
// Self-checking bench for breath_pwm_multi: counts high cycles per 16-cycle PWM period
// on a STEP_DIV=1 and a STEP_DIV=3 instance and compares them against table entries.
module tb_breath_pwm_multi;

  localparam int W  = 4;
  localparam int CH = 4;

  typedef struct {
    bit slow;
    int win;
    int ch;
    int duty;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic [CH-1:0] pwm_main;
  logic [CH-1:0] pwm_slow;
  logic          tick_main;
  logic          tick_slow;

  int n_vec  = 0;
  int n_fail = 0;
  int tick_err = 0;
  int hi_main [0:19][0:CH-1];
  int hi_slow [0:19][0:CH-1];
  int stagger [0:CH-1] = '{0, 4, 8, 12};

  vec_t tri_tbl[$];
  vec_t saw_tbl[$];

  breath_pwm_multi #(.WIDTH(W), .CHANNELS(CH), .STEP_DIV(1)) u_main (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .pwm_out(pwm_main), .period_tick(tick_main)
  );

  breath_pwm_multi #(.WIDTH(W), .CHANNELS(CH), .STEP_DIV(3)) u_slow (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .pwm_out(pwm_slow), .period_tick(tick_slow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int eff_of(input int d);
`ifdef BREATH_PWM_GAMMA_EN
    return (d * d) >> W;
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int w = 0; w < 20; w++)
      for (int c = 0; c < CH; c++) begin
        hi_main[w][c] = 0;
        hi_slow[w][c] = 0;
      end
    tick_err = 0;
  endtask

  task automatic do_reset(input bit m);
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    mode   = m;
    repeat (2) @(negedge clk);
    check("reset pwm_main", int'(pwm_main), 0);
    check("reset pwm_slow", int'(pwm_slow), 0);
    check("reset period_tick", int'(tick_main) + int'(tick_slow), 0);
    reset = 1'b0;
    clear_counts();
  endtask

  // One clock of window w; sample s runs 1..16 and the tick belongs on sample 16.
  task automatic sample_cycle(input int w, input int s);
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      hi_main[w][c] += int'(pwm_main[c]);
      hi_slow[w][c] += int'(pwm_slow[c]);
    end
    if (tick_main !== (s == 16)) tick_err++;
    if (tick_slow !== (s == 16)) tick_err++;
    if (s == 16) begin
      check($sformatf("period_tick w%0d", w), tick_err, 0);
      tick_err = 0;
    end
  endtask

  task automatic run_windows(input int first, input int n);
    for (int w = first; w < first + n; w++)
      for (int s = 1; s <= 16; s++) sample_cycle(w, s);
  endtask

  task automatic apply(input vec_t v, input string tag);
    int act;
    act = v.slow ? hi_slow[v.win][v.ch] : hi_main[v.win][v.ch];
    check($sformatf("%s %s w%0d ch%0d", tag, v.slow ? "slow" : "main", v.win, v.ch),
          act, eff_of(v.duty));
  endtask

  initial begin
    int tot [0:CH-1];

    // Triangle: stagger, ch3 turnaround, ch0 top, slow divider.
    tri_tbl.push_back('{0, 0, 0, 0});
    tri_tbl.push_back('{0, 0, 1, 4});
    tri_tbl.push_back('{0, 0, 2, 8});
    tri_tbl.push_back('{0, 0, 3, 12});
    tri_tbl.push_back('{0, 1, 3, 13});
    tri_tbl.push_back('{0, 2, 3, 14});
    tri_tbl.push_back('{0, 3, 3, 15});
    tri_tbl.push_back('{0, 4, 3, 14});
    tri_tbl.push_back('{0, 5, 3, 13});
    tri_tbl.push_back('{0, 1, 0, 1});
    tri_tbl.push_back('{0, 2, 0, 2});
    tri_tbl.push_back('{0, 15, 0, 15});
    tri_tbl.push_back('{0, 16, 0, 14});
    tri_tbl.push_back('{0, 7, 2, 15});
    tri_tbl.push_back('{0, 8, 2, 14});
    tri_tbl.push_back('{1, 0, 3, 12});
    tri_tbl.push_back('{1, 1, 3, 12});
    tri_tbl.push_back('{1, 2, 3, 12});
    tri_tbl.push_back('{1, 3, 3, 13});
    tri_tbl.push_back('{1, 5, 3, 13});
    tri_tbl.push_back('{1, 6, 3, 14});
    tri_tbl.push_back('{1, 3, 0, 1});
    // Sawtooth: ch3 wraps, ch0 and ch1 wrap later.
    saw_tbl.push_back('{0, 0, 3, 12});
    saw_tbl.push_back('{0, 1, 3, 13});
    saw_tbl.push_back('{0, 3, 3, 15});
    saw_tbl.push_back('{0, 4, 3, 0});
    saw_tbl.push_back('{0, 5, 3, 1});
    saw_tbl.push_back('{0, 15, 0, 15});
    saw_tbl.push_back('{0, 16, 0, 0});
    saw_tbl.push_back('{0, 12, 1, 0});
    saw_tbl.push_back('{1, 3, 3, 13});

    do_reset(1'b0);
    run_windows(0, 17);
    foreach (tri_tbl[k]) apply(tri_tbl[k], "tri");

    do_reset(1'b1);
    run_windows(0, 17);
    foreach (saw_tbl[k]) apply(saw_tbl[k], "saw");

    // Mode flips mid-period while ch3 sits at MAX: no glitch, then sawtooth wrap to 0.
    do_reset(1'b0);
    run_windows(0, 3);
    for (int s = 1; s <= 16; s++) begin
      sample_cycle(3, s);
      if (s == 8) mode = 1'b1;
    end
    run_windows(4, 1);
    check("modeswitch w3 ch3", hi_main[3][3], eff_of(15));
    check("modeswitch w4 ch3", hi_main[4][3], eff_of(0));
    check("modeswitch w4 ch0", hi_main[4][0], eff_of(4));

    // Freeze after cnt=5 was compared, hold 5 cycles, then finish the period from cnt=6.
    do_reset(1'b0);
    for (int c = 0; c < CH; c++) tot[c] = 0;
    for (int s = 1; s <= 6; s++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) tot[c] += int'(pwm_main[c]);
      if (tick_main !== 1'b0) tick_err++;
    end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("freeze pwm_out", int'(pwm_main), 0);
      check("freeze period_tick", int'(tick_main), 0);
    end
    enable = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) tot[c] += int'(pwm_main[c]);
      if (tick_main !== (s == 10)) tick_err++;
    end
    check("resume period_tick", tick_err, 0);
    tick_err = 0;
    for (int c = 0; c < CH; c++)
      check($sformatf("resume total ch%0d", c), tot[c], eff_of(stagger[c]));
    clear_counts();
    run_windows(1, 1);
    check("resume next w ch3", hi_main[1][3], eff_of(13));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
